load_store_unit: RTL and testbench

Memory-side stage between the single-cycle datapath and the data memory. Accepts one load or store per request from the datapath's memory stage and converts it to word-aligned, byte-enabled accesses on a valid/ready memory port. Performs RV32I byte/halfword lane steering and load sign/zero extension, and stalls the datapath until the access completes. Misaligned accesses are either split into two word beats or faulted, selected at compile time.

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane steering, load extension and a valid/ready word port.
// Define LSU_SPLIT_MISALIGNED_EN to split word-crossing accesses into two beats; otherwise they fault.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state_q, state_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_fault_q, rsp_fault_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            k_q, k_d;
`ifdef LSU_SPLIT_MISALIGNED_EN
    logic                  cross_q, cross_d;
    logic [3:0]            be_hi_q, be_hi_d;
    logic [31:0]           wdata_hi_q, wdata_hi_d;
    logic [31:0]           rdata0_q, rdata0_d;
    logic [63:0]           wdata_wide;
`else
    logic [31:0]           wdata_lo;
`endif

    logic [3:0]  size_mask;
    logic [7:0]  be8;
    logic [31:0] lane;
    logic [4:0]  wshift;
    logic        req_cross;
    logic        req_illegal;

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (f)
            3'b000:  load_extend = 32'(b);
            3'b001:  load_extend = 32'(h);
            3'b100:  load_extend = {24'b0, w[7:0]};
            3'b101:  load_extend = {16'b0, w[15:0]};
            default: load_extend = w;
        endcase
    endfunction

    // Request decode: an 8-bit enable window whose upper nibble belongs to the second word.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be8         = {4'b0000, size_mask} << req_addr[1:0];
        req_cross   = |be8[7:4];
        req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_funct3[2] && req_we);
        case (req_funct3[1:0])
            2'b00:   lane = {4{req_wdata[7:0]}};
            2'b01:   lane = {16'b0, req_wdata[15:0]};
            default: lane = req_wdata;
        endcase
        // Replicated bytes already sit in every lane, so they are never shifted.
        wshift = (req_funct3[1:0] == 2'b00) ? 5'd0 : {req_addr[1:0], 3'b000};
`ifdef LSU_SPLIT_MISALIGNED_EN
        wdata_wide = {32'b0, lane} << wshift;
`else
        wdata_lo   = lane << wshift;
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        funct3_d    = funct3_q;
        k_d         = k_q;
`ifdef LSU_SPLIT_MISALIGNED_EN
        cross_d     = cross_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
        rdata0_d    = rdata0_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d    = req_funct3;
                    k_d         = req_addr[1:0];
                    rsp_rdata_d = 32'b0;
`ifdef LSU_SPLIT_MISALIGNED_EN
                    if (req_illegal) begin
`else
                    if (req_illegal || req_cross) begin
`endif
                        rsp_fault_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        rsp_fault_d = 1'b0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = be8[3:0];
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef LSU_SPLIT_MISALIGNED_EN
                        mem_wdata_d = wdata_wide[31:0];
                        wdata_hi_d  = wdata_wide[63:32];
                        be_hi_d     = be8[7:4];
                        cross_d     = req_cross;
`else
                        mem_wdata_d = wdata_lo;
`endif
                        state_d     = ACC0;
                    end
                end
            end
            ACC0: begin
                if (mem_ready) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
                    rdata0_d = mem_rdata;
                    if (cross_q) begin
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wdata_hi_q;
                        state_d     = ACC1;
                    end else begin
                        mem_valid_d = 1'b0;
                        rsp_rdata_d = mem_we_q ? 32'b0 :
                                      load_extend(mem_rdata >> {k_q, 3'b000}, funct3_q);
                        state_d     = RESP;
                    end
`else
                    mem_valid_d = 1'b0;
                    rsp_rdata_d = mem_we_q ? 32'b0 :
                                  load_extend(mem_rdata >> {k_q, 3'b000}, funct3_q);
                    state_d     = RESP;
`endif
                end
            end
            ACC1: begin
`ifdef LSU_SPLIT_MISALIGNED_EN
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    rsp_rdata_d = mem_we_q ? 32'b0 :
                                  load_extend(32'({mem_rdata, rdata0_q} >> {k_q, 3'b000}), funct3_q);
                    state_d     = RESP;
                end
`else
                mem_valid_d = 1'b0;
                state_d     = IDLE;
`endif
            end
            default: begin
                rsp_fault_d = 1'b0;
                rsp_rdata_d = 32'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            rsp_rdata_q <= 32'b0;
            rsp_fault_q <= 1'b0;
            funct3_q    <= 3'b0;
            k_q         <= 2'b0;
`ifdef LSU_SPLIT_MISALIGNED_EN
            cross_q     <= 1'b0;
            be_hi_q     <= 4'b0;
            wdata_hi_q  <= 32'b0;
            rdata0_q    <= 32'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            funct3_q    <= funct3_d;
            k_q         <= k_d;
`ifdef LSU_SPLIT_MISALIGNED_EN
            cross_q     <= cross_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata0_q    <= rdata0_d;
`endif
        end
    end

    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == ACC0) || (state_q == ACC1);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        stall, rsp_valid, rsp_fault, mem_valid, mem_we;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'b0;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    endtask

    task automatic retire();
        req_valid = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({stall, rsp_valid, rsp_fault, rsp_rdata} !== 35'b0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {stall, rsp_valid, rsp_fault, rsp_rdata}); end
        checks++; if ({mem_valid, mem_we, mem_be, mem_addr, mem_wdata} !== 70'b0) begin errors++; $display("FAIL reset_mem got=%h exp=0", {mem_valid, mem_we, mem_be, mem_addr, mem_wdata}); end
        step(); step();
        rst = 1'b1;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall got=%b exp=0", stall); end
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        checks++; if ({stall, mem_valid} !== 2'b10) begin errors++; $display("FAIL lw_accept got=%b exp=10", {stall, mem_valid}); end
        step();
        checks++; if ({mem_valid, mem_we, mem_be} !== 6'b101111) begin errors++; $display("FAIL lw_ctl got=%b exp=101111", {mem_valid, mem_we, mem_be}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h exp=00000100", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        checks++; if ({rsp_valid, rsp_fault, stall, mem_valid} !== 4'b1000) begin errors++; $display("FAIL lw_rsp_flags got=%b exp=1000", {rsp_valid, rsp_fault, stall, mem_valid}); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", rsp_rdata); end
        retire();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h203, 32'h000000A5);
        step();
        checks++; if ({mem_valid, mem_we, mem_be} !== 6'b111000) begin errors++; $display("FAIL sb_ctl got=%b exp=111000", {mem_valid, mem_we, mem_be}); end
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got=%h exp=00000200", mem_addr); end
        checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
        mem_ready = 1'b1;
        step();
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL sb_rsp got=%b/%h exp=1/0", rsp_valid, rsp_rdata); end
        retire();
        issue(1'b0, 3'b000, 32'h203, 32'h0);
        step();
        checks++; if ({mem_we, mem_be} !== 5'b01000) begin errors++; $display("FAIL lb_ctl got=%b exp=01000", {mem_we, mem_be}); end
        mem_ready = 1'b1; mem_rdata = 32'h80000000;
        step();
        checks++; if (rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h exp=ffffff80", rsp_rdata); end
        retire();
        issue(1'b0, 3'b100, 32'h203, 32'h0);
        step();
        mem_ready = 1'b1;
        step();
        checks++; if (rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got=%h exp=00000080", rsp_rdata); end
        retire();
    endtask

    task automatic test_half();
        issue(1'b0, 3'b001, 32'h101, 32'h0);
        step();
        checks++; if (mem_be !== 4'b0110) begin errors++; $display("FAIL lh_be got=%b exp=0110", mem_be); end
        mem_ready = 1'b1; mem_rdata = 32'h00F00F00;
        step();
        checks++; if (rsp_rdata !== 32'hFFFFF00F) begin errors++; $display("FAIL lh_sext got=%h exp=fffff00f", rsp_rdata); end
        retire();
        issue(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
        step();
        checks++; if ({mem_be, mem_wdata} !== {4'b1100, 32'hBEEF0000}) begin errors++; $display("FAIL sh_lane got=%b/%h exp=1100/beef0000", mem_be, mem_wdata); end
        mem_ready = 1'b1;
        step();
        retire();
    endtask

    task automatic test_stall();
        issue(1'b0, 3'b101, 32'h101, 32'h0);
        step();
        mem_ready = 1'b0; mem_rdata = 32'h00F00F00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({stall, mem_valid, mem_we, mem_be, mem_addr, rsp_valid} !== {3'b110, 4'b0110, 32'h100, 1'b0})
                begin errors++; $display("FAIL stall_hold%0d got=%b/%b/%h exp=1/0110/100", i, {stall, mem_valid, rsp_valid}, mem_be, mem_addr); end
        end
        mem_ready = 1'b1;
        step();
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000F00F}) begin errors++; $display("FAIL stall_rsp got=%b/%h exp=1/0000f00f", rsp_valid, rsp_rdata); end
        retire();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_SPLIT_MISALIGNED_EN
        step();
        checks++; if ({mem_valid, mem_be, mem_addr} !== {1'b1, 4'b1100, 32'h100}) begin errors++; $display("FAIL split_b0 got=%b/%h exp=1100/100", mem_be, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h5678ABCD;
        step();
        checks++; if ({mem_valid, rsp_valid, mem_be, mem_addr} !== {2'b10, 4'b0011, 32'h104}) begin errors++; $display("FAIL split_b1 got=%b/%h exp=0011/104", mem_be, mem_addr); end
        mem_rdata = 32'hEF011234;
        step();
        checks++; if ({rsp_valid, rsp_fault, rsp_rdata} !== {2'b10, 32'h12345678}) begin errors++; $display("FAIL split_rsp got=%b/%h exp=10/12345678", {rsp_valid, rsp_fault}, rsp_rdata); end
        retire();
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        step();
        checks++; if (mem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_b0 got=%h exp=fffffffc", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h22220000;
        step();
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_b1 got=%h exp=0", mem_addr); end
        mem_rdata = 32'h00003333;
        step();
        checks++; if (rsp_rdata !== 32'h33332222) begin errors++; $display("FAIL wrap_rsp got=%h exp=33332222", rsp_rdata); end
        retire();
`else
        #1;
        checks++; if ({stall, mem_valid} !== 2'b10) begin errors++; $display("FAIL trap_accept got=%b exp=10", {stall, mem_valid}); end
        step();
        checks++; if ({rsp_valid, rsp_fault, mem_valid, rsp_rdata} !== {3'b110, 32'h0}) begin errors++; $display("FAIL trap_rsp got=%b/%h exp=110/0", {rsp_valid, rsp_fault, mem_valid}, rsp_rdata); end
        retire();
        issue(1'b1, 3'b001, 32'h203, 32'h1234);
        step();
        checks++; if ({rsp_valid, rsp_fault, mem_valid} !== 3'b110) begin errors++; $display("FAIL trap_sh3 got=%b exp=110", {rsp_valid, rsp_fault, mem_valid}); end
        retire();
`endif
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        step();
        checks++; if ({rsp_valid, rsp_fault, mem_valid, stall} !== 4'b1100) begin errors++; $display("FAIL ill_011 got=%b exp=1100", {rsp_valid, rsp_fault, mem_valid, stall}); end
        retire();
        checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL ill_clear got=%b exp=0", rsp_fault); end
        issue(1'b1, 3'b100, 32'h100, 32'h0);
        step();
        checks++; if ({rsp_valid, rsp_fault, mem_valid} !== 3'b110) begin errors++; $display("FAIL ill_sbu got=%b exp=110", {rsp_valid, rsp_fault, mem_valid}); end
        retire();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        step();
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rmid_acc0 got=%b exp=1", mem_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rmid_drop got=%b exp=0", mem_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_norsp got=%b exp=0", rsp_valid); end
        rst = 1'b1;
        step();
        checks++; if ({mem_valid, mem_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rmid_retry got=%b/%h exp=1/300", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h11223344;
        step();
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL rmid_rsp got=%b/%h exp=1/11223344", rsp_valid, rsp_rdata); end
        retire();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte();
        test_half();
        test_stall();
        test_misaligned();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
